// File: rtl/tt_ctrl_sel_seq_pkg.sv
// Shared definitions for the tt_top mux-control sequencer: state encoding,
// address field layout and default timing.
package tt_ctrl_sel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_INC_HI = 3'd2,
        ST_INC_LO = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACT    = 3'd5
    } state_t;

    // Linear design address: Y in the upper field, X in the lower field
    localparam int DEF_ADDR_W = 10;
    localparam int Y_W        = 5;
    localparam int X_W        = 5;
    localparam int Y_LSB      = 5;
    localparam int X_LSB      = 0;

    localparam int DEF_RST_LEN = 4;
    localparam int DEF_INC_GAP = 1;
    localparam int DEF_SETTLE  = 2;

    function automatic logic [DEF_ADDR_W-1:0] make_addr(input logic [Y_W-1:0] y,
                                                        input logic [X_W-1:0] x);
        logic [DEF_ADDR_W-1:0] a;
        a = '0;
        a[Y_LSB +: Y_W] = y;
        a[X_LSB +: X_W] = x;
        return a;
    endfunction

endpackage

// File: rtl/tt_ctrl_pulse_gen.sv
// Emits a train of N single-cycle increment pulses, each followed by INC_GAP
// low cycles. The parent never loads with N=0.
module tt_ctrl_pulse_gen #(
    parameter int ADDR_W  = 10,
    parameter int INC_GAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] n,
    output logic              inc,
    output logic              last,
    output logic              gap_done
);

    localparam int GAP_W = (INC_GAP > 1) ? $clog2(INC_GAP) : 1;

    logic              busy;
    logic [ADDR_W-1:0] rem;
    logic [GAP_W-1:0]  gap_cnt;

    // rem counts pulses still owed after the one currently high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc     <= 1'b0;
            busy    <= 1'b0;
            rem     <= '0;
            gap_cnt <= '0;
        end else if (load) begin
            inc     <= 1'b1;
            busy    <= 1'b1;
            rem     <= n - ADDR_W'(1);
            gap_cnt <= '0;
        end else if (inc) begin
            inc     <= 1'b0;
            gap_cnt <= GAP_W'(INC_GAP - 1);
        end else if (busy) begin
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end else if (rem != '0) begin
                inc <= 1'b1;
                rem <= rem - ADDR_W'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign last     = inc && (rem == '0);
    assign gap_done = busy && !inc && (gap_cnt == '0);

endmodule

// File: rtl/tt_ctrl_sel_seq.sv
// Drives tt_top's ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena to select a user
// design by linear address, tracking chain position so forward moves skip the reset.
module tt_ctrl_sel_seq
    import tt_ctrl_sel_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RST_LEN = DEF_RST_LEN,
    parameter int INC_GAP = DEF_INC_GAP,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              dis,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              active,
    output logic              done,
    output state_t            dbg_state
);

    localparam int RST_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state;
    logic              pos_valid;
    logic              last_seen;
    logic [ADDR_W-1:0] tgt_n;
    logic [RST_W-1:0]  rst_cnt;
    logic [SET_W-1:0]  settle_cnt;

    logic              accept;
    logic              full_path;
    logic              rst_last;
    logic [ADDR_W-1:0] step_n;
    logic              pg_load;
    logic [ADDR_W-1:0] pg_n;
    logic              pg_last;
    logic              pg_gap_done;

    // Handshake: a request transfers on a posedge where req_valid && req_ready.
    // req_ready is high only in IDLE and ACT; a requester seeing it low must
    // hold req_valid and req_addr stable. Nothing is queued.
    always_comb begin
        accept    = req_valid && req_ready;
        full_path = !pos_valid || (req_addr < cur_addr);
        step_n    = req_addr - cur_addr;
        rst_last  = (state == ST_RST) && (rst_cnt == '0);
        pg_load   = (accept && !full_path && (step_n != '0)) ||
                    (rst_last && (tgt_n != '0));
        pg_n      = rst_last ? tgt_n : step_n;
    end

    tt_ctrl_pulse_gen #(
        .ADDR_W  (ADDR_W),
        .INC_GAP (INC_GAP)
    ) u_pulse_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pg_load),
        .n        (pg_n),
        .inc      (ctrl_sel_inc),
        .last     (pg_last),
        .gap_done (pg_gap_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_ena       <= 1'b0;
            active         <= 1'b0;
            done           <= 1'b0;
            req_ready      <= 1'b1;
            cur_addr       <= '0;
            pos_valid      <= 1'b0;
            last_seen      <= 1'b0;
            tgt_n          <= '0;
            rst_cnt        <= '0;
            settle_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_ACT: begin
                    // A request beats a simultaneous dis
                    if (accept) begin
                        ctrl_ena  <= 1'b0;
                        active    <= 1'b0;
                        req_ready <= 1'b0;
                        if (full_path) begin
                            state          <= ST_RST;
                            ctrl_sel_rst_n <= 1'b0;
                            rst_cnt        <= RST_W'(RST_LEN - 1);
                            tgt_n          <= req_addr;
                        end else if (step_n != '0) begin
                            state <= ST_INC_HI;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SET_W'(SETTLE - 1);
                        end
                    end else if ((state == ST_ACT) && dis) begin
                        state    <= ST_IDLE;
                        ctrl_ena <= 1'b0;
                        active   <= 1'b0;
                    end
                end
                ST_RST: begin
                    cur_addr  <= '0;
                    pos_valid <= 1'b1;
                    if (rst_cnt == '0) begin
                        ctrl_sel_rst_n <= 1'b1;
                        if (tgt_n != '0) begin
                            state <= ST_INC_HI;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SET_W'(SETTLE - 1);
                        end
                    end else begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end
                ST_INC_HI: begin
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    last_seen <= pg_last;
                    state     <= ST_INC_LO;
                end
                ST_INC_LO: begin
                    if (pg_gap_done) begin
                        if (last_seen) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SET_W'(SETTLE - 1);
                        end else begin
                            state <= ST_INC_HI;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= ST_ACT;
                        ctrl_ena  <= 1'b1;
                        active    <= 1'b1;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
